// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control path and its time-counter datapath.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } sw_state_t;

  localparam int unsigned TICK_DIV_DEFAULT = 50_000_000;

  localparam int unsigned SEC_MAX  = 59;
  localparam int unsigned MIN_MAX  = 59;
  localparam int unsigned HOUR_MAX = 23;

endpackage

// File: rtl/sw_tick_gen.sv
// Prescaler turning clk into one-cycle count-enable ticks every TICK_DIV running cycles.
module sw_tick_gen
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int unsigned W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] presc;

  // Clear wins over a coinciding wrap so the counter never sees tick and clear together;
  // when not running the prescaler holds, keeping the sub-second fraction across pause.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      tick  <= 1'b0;
    end else if (clr) begin
      presc <= '0;
      tick  <= 1'b0;
    end else if (run) begin
      if (presc == LAST) begin
        presc <= '0;
        tick  <= 1'b1;
      end else begin
        presc <= presc + W'(1);
        tick  <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: button press detection, run/pause/lap FSM and count-tick generation.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start_stop,
  input  logic       btn_lap,
  input  logic       btn_clear,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       disp_hold,
  output logic       running,
  output logic [1:0] state
);

  logic      ss_q, lap_q, clr_q;
  logic      ss_press, lap_press, clr_press;
  logic      counting;
  sw_state_t state_q, state_d;

  assign ss_press  = btn_start_stop & ~ss_q;
  assign lap_press = btn_lap & ~lap_q;
  assign clr_press = btn_clear & ~clr_q;
  assign counting  = (state_q == RUN) || (state_q == LAP);
  assign state     = state_q;

  // Priority clear > start_stop > lap: lower-priority presses on the same edge are dropped.
  always_comb begin
    state_d = state_q;
    if (clr_press) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (ss_press) state_d = RUN;
        RUN:     if (ss_press) state_d = PAUSE;
                 else if (lap_press) state_d = LAP;
        LAP:     if (ss_press) state_d = PAUSE;
                 else if (lap_press) state_d = RUN;
        PAUSE:   if (ss_press) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_q      <= 1'b0;
      lap_q     <= 1'b0;
      clr_q     <= 1'b0;
      state_q   <= IDLE;
      cnt_clr   <= 1'b0;
      disp_hold <= 1'b0;
      running   <= 1'b0;
    end else begin
      ss_q      <= btn_start_stop;
      lap_q     <= btn_lap;
      clr_q     <= btn_clear;
      state_q   <= state_d;
      cnt_clr   <= clr_press;
      disp_hold <= (state_d == LAP);
      running   <= (state_d == RUN) || (state_d == LAP);
    end
  end

  sw_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (counting),
    .clr  (clr_press),
    .tick (cnt_en)
  );

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with TICK_DIV=4: vector table, corner sequences, random run.
module tb_stopwatch_ctrl;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bss = 1'b0;
  logic       blap = 1'b0;
  logic       bclr = 1'b0;
  logic       cnt_en, cnt_clr, disp_hold, running;
  logic [1:0] state;

  int tests = 0;
  int fails = 0;

  stopwatch_ctrl #(
    .TICK_DIV(TD)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_start_stop(bss),
    .btn_lap       (blap),
    .btn_clear     (bclr),
    .cnt_en        (cnt_en),
    .cnt_clr       (cnt_clr),
    .disp_hold     (disp_hold),
    .running       (running),
    .state         (state)
  );

  always #5 clk = ~clk;

  // Reference model: mode uses the published state codes 0=idle 1=run 2=pause 3=lap,
  // frac counts running cycles since the last second boundary.
  int m_mode, m_frac;
  bit m_en, m_clr, m_pss, m_plap, m_pclr;

  function automatic void model_reset();
    m_mode = 0; m_frac = 0; m_en = 0; m_clr = 0;
    m_pss = 0; m_plap = 0; m_pclr = 0;
  endfunction

  function automatic void model_edge(bit ss, bit lp, bit cl);
    bit e_ss, e_lap, e_clr, counting;
    e_ss  = ss && !m_pss;
    e_lap = lp && !m_plap;
    e_clr = cl && !m_pclr;
    counting = (m_mode == 1) || (m_mode == 3);
    m_en = 0;
    m_clr = 0;
    if (e_clr) begin
      m_mode = 0;
      m_frac = 0;
      m_clr = 1;
    end else begin
      if (counting) begin
        m_frac = m_frac + 1;
        if (m_frac == TD) begin
          m_frac = 0;
          m_en = 1;
        end
      end
      if (e_ss) m_mode = counting ? 2 : 1;
      else if (e_lap && m_mode == 1) m_mode = 3;
      else if (e_lap && m_mode == 3) m_mode = 1;
    end
    m_pss = ss; m_plap = lp; m_pclr = cl;
  endfunction

  function automatic logic [5:0] model_vec();
    logic [1:0] s;
    s = m_mode[1:0];
    return {s, m_en, m_clr, (m_mode == 3), (m_mode == 1 || m_mode == 3)};
  endfunction

  function automatic logic [5:0] dut_vec();
    return {state, cnt_en, cnt_clr, disp_hold, running};
  endfunction

  task automatic check(input string name, input logic [5:0] exp);
    logic [5:0] act;
    act = dut_vec();
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: {state,en,clr,hold,run} got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit ss, input bit lp, input bit cl, input string name);
    bss = ss; blap = lp; bclr = cl;
    @(posedge clk);
    model_edge(ss, lp, cl);
    #1;
    check(name, model_vec());
  endtask

  // Asynchronous reset pulse placed mid-cycle; outputs must drop before any clock edge.
  task automatic reset_mid(input string name);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check(name, 6'b000000);
    @(posedge clk);
    #1;
    check(name, 6'b000000);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit ss;
    bit lp;
    bit cl;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[21];

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 6'b000000};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 6'b010001};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 6'b010001};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 6'b010001};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 6'b010001};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 6'b011001};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 6'b110011};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 6'b110011};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 6'b110011};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 6'b111011};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 6'b010001};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 6'b100000};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 6'b100000};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 6'b100000};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 6'b010001};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 6'b010001};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 6'b011001};
    tbl[17] = '{1'b0, 1'b0, 1'b1, 6'b000100};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 6'b000000};
    tbl[19] = '{1'b0, 1'b0, 1'b1, 6'b000100};
    tbl[20] = '{1'b0, 1'b0, 1'b0, 6'b000000};

    model_reset();
    #23;
    check("reset_state", 6'b000000);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, "idle_model");
      check("idle_const", 6'b000000);
    end

    // Held start_stop: one event, ticks on cycles 4, 8, 12.
    for (int k = 0; k <= 12; k++) begin
      step(k < 10, 0, 0, "start_hold");
      check_bit($sformatf("start_tick_k%0d", k), cnt_en, (k > 0) && (k % 4 == 0));
      if (k == 0) check_bit("start_state_run", (state == 2'b01), 1'b1);
    end
    step(0, 0, 1, "clear_before_table");
    step(0, 0, 0, "settle");

    for (int i = 0; i < 21; i++) begin
      step(tbl[i].ss, tbl[i].lp, tbl[i].cl, $sformatf("table_model[%0d]", i));
      check($sformatf("table[%0d]", i), tbl[i].exp);
    end

    // lap together with start_stop while in LAP: start_stop wins.
    step(1, 0, 0, "lapss_run");
    step(0, 1, 0, "lapss_lap");
    step(1, 1, 0, "lapss_both");
    check("lap_with_ss", 6'b100000);
    step(0, 0, 0, "lapss_idle");
    step(0, 0, 1, "lapss_clear");
    step(0, 0, 0, "lapss_settle");

    // Clear landing on the tick-boundary edge.
    step(1, 0, 0, "cb_start");
    for (int i = 0; i < 3; i++) step(0, 0, 0, "cb_run");
    step(0, 0, 1, "cb_clear");
    check("clear_on_boundary", 6'b000100);
    step(1, 0, 0, "cb_restart");
    check("restart_state", 6'b010001);
    for (int i = 1; i <= 4; i++) begin
      step(0, 0, 0, "cb_after");
      check_bit($sformatf("restart_tick_%0d", i), cnt_en, i == 4);
    end

    // Pause on the tick-boundary edge: tick still issued.
    for (int i = 0; i < 3; i++) step(0, 0, 0, "pb_run");
    step(1, 0, 0, "pb_pause");
    check("pause_on_boundary", 6'b101000);
    step(0, 0, 0, "pb_hold");
    check("pause_no_tick", 6'b100000);

    // All three buttons on one edge in RUN.
    step(1, 0, 0, "all3_resume");
    step(0, 0, 0, "all3_run");
    step(1, 1, 1, "all3_press");
    check("all_three", 6'b000100);
    step(0, 0, 0, "all3_idle");

    // Reset mid-RUN with a tick pending on the next edge.
    step(1, 0, 0, "rst_start");
    for (int i = 0; i < 3; i++) step(0, 0, 0, "rst_run");
    reset_mid("reset_mid_run");
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, "post_reset_model");
      check("post_reset_quiet", 6'b000000);
    end

    // Randomised button activity against the reference model.
    for (int i = 0; i < 3000; i++) begin
      bit ss, lp, cl;
      ss = bss; lp = blap; cl = bclr;
      if ($urandom_range(0, 5) == 0) ss = !ss;
      if ($urandom_range(0, 5) == 0) lp = !lp;
      if ($urandom_range(0, 19) == 0) cl = !cl;
      step(ss, lp, cl, "random");
      if ($urandom_range(0, 399) == 0) reset_mid("random_reset");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control-path sequencer for the stopwatch time counter. It turns raw start/stop, lap and clear button levels into single press events. It runs a state machine and prescales clk into one-cycle count-enable pulses. It drives the counter's enable and clear and a display-hold flag for lap freeze. It sits between the button synchronisers/debouncers and the sec/min/hour counter datapath.

Parameters:
TICK_DIV, 50_000_000, clk cycles per count tick (1 s at 50 MHz); legal range >= 2.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
btn_start_stop  input  1  debounced, clk-synchronous level; each rising edge is one press.
btn_lap  input  1  debounced, clk-synchronous level; each rising edge is one press.
btn_clear  input  1  debounced, clk-synchronous level; each rising edge is one press.
cnt_en  output  1  one-cycle pulse: advance time counter by one second.
cnt_clr  output  1  one-cycle pulse: zero the time counter.
disp_hold  output  1  high = display keeps its last latched value (lap view).
running  output  1  high in RUN or LAP.
state  output  2  current FSM state encoding.

Behaviour:
- Reset (rst_n low, async): state=IDLE, prescaler=0, button history regs=0, cnt_en=0, cnt_clr=0, disp_hold=0, running=0.
- Button history resets to 0, so a button already high at reset release yields one press on the first clk edge.
- Press event: press = btn & ~btn_q, where btn_q is the previous-cycle sample. A held button gives exactly one event. The state acts on the event at the same edge it is sampled.
- Same-edge priority: clear > start_stop > lap. Lower-priority events on that edge are discarded.
- States and encodings: IDLE=00, RUN=01, PAUSE=10, LAP=11.
- IDLE: start_stop -> RUN. clear -> IDLE plus cnt_clr pulse. lap is ignored.
- RUN: start_stop -> PAUSE. lap -> LAP. clear -> IDLE plus cnt_clr.
- LAP: lap -> RUN. start_stop -> PAUSE. clear -> IDLE plus cnt_clr.
- PAUSE: start_stop -> RUN. clear -> IDLE plus cnt_clr. lap is ignored.
- disp_hold is a registered output: high exactly while state==LAP. It drops on the edge LAP is left.
- running is a registered output: high while state is RUN or LAP.
- Counting continues in LAP; only the display freezes.
- Prescaler width is clog2(TICK_DIV).
- Prescaler increments on each edge where state (pre-edge) is RUN or LAP.
- At TICK_DIV-1 the prescaler wraps to 0 and cnt_en is registered high for the next cycle.
- PAUSE holds the prescaler value, so the sub-second fraction is preserved across pause/resume.
- Clear zeroes the prescaler.
- cnt_en timing: start_stop sampled at edge 0 from IDLE puts RUN in effect after edge 0. With TICK_DIV=4, cnt_en is high between edges 4 and 5, then 8 and 9, and so on.
- Pause on a tick-boundary edge (prescaler==TICK_DIV-1): that tick is still issued and the prescaler wraps to 0.
- Clear on a tick-boundary edge: cnt_en is suppressed (0) and cnt_clr=1. The counter must never see both pulses in the same cycle.
- cnt_clr is registered and high for exactly one cycle per accepted clear. Clear in IDLE still pulses.
- Reset mid-operation: all outputs return to their reset values immediately, with no pending tick or clear issued afterwards.
- No combinational path from any input to any output.

Decomposition:
- Shared package stopwatch_pkg:
  - state encodings (sw_state_t: IDLE, RUN, PAUSE, LAP);
  - default TICK_DIV constant;
  - second/minute/hour limit constants (59, 59, 23) for reuse by the counter datapath.
- One sub-module, sw_tick_gen:
  - inputs: clk, rst_n, run, clr;
  - output: tick;
  - parameter: TICK_DIV;
  - holds prescaler and tick register.
- Edge detection and FSM stay in stopwatch_ctrl.

Test Plan:
- Reset release with all buttons low, TICK_DIV=4: all outputs 0 and state=00 for 20 cycles, no cnt_en.
- start_stop press, hold 10 cycles, TICK_DIV=4: state=01 after 1 edge and one event only. cnt_en pulses at cycles 4, 8, 12, each exactly 1 cycle wide.
- Run 6 cycles, pause 5 cycles, resume, TICK_DIV=4: the first tick after resume arrives 2 running edges later (fraction kept). No cnt_en while in PAUSE.
- In RUN press lap: disp_hold=1 and state=11, cnt_en continues every 4 cycles. Press lap again: disp_hold=0, state=01. Press lap in LAP together with start_stop: state=10, disp_hold=0.
- Clear asserted on the same edge prescaler==3: cnt_en=0, cnt_clr=1 for one cycle, state=00, prescaler=0. A following start gives its first tick 4 edges later.
- All three buttons rising on one edge in RUN: only clear acts, giving state=00 and cnt_clr=1. Pulse rst_n low mid-RUN for 1 cycle: outputs 0 asynchronously, and no tick follows release.
